rx_frame_collector: RTL and testbench
=====================================

# rx_frame_collector

Downstream stage of the packet-processing DUT: consumes the byte stream it drives on `txd`/`tx_en`, delimits frames by the valid strobe, and buffers bytes with an end-of-frame flag in a FIFO. The FIFO and the statistics counters are exposed on the same register bus as the upstream DUT. Software or the bus agent drains frames by reading the DATA register.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries (power of 2, ≥4); each entry is {last, byte[7:0]}.
- `BASE_ADDR`, 16'h10: address of the first register; the block decodes BASE_ADDR..BASE_ADDR+5.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rxd`  in  8  byte stream, driven by the upstream `txd`.
- `rx_dv`  in  1  byte valid, driven by the upstream `tx_en`; a frame is a maximal run of consecutive high cycles.
- `bus_cmd_valid`  in  1  bus command strobe, one cycle.
- `bus_op`  in  1  1 = write, 0 = read.
- `bus_addr`  in  16  register address.
- `bus_wr_data`  in  16  write data.
- `bus_rd_data`  out  16  registered read data.
- `fifo_nempty`  out  1  FIFO holds at least one entry.

## Operation
Register map (offset from BASE_ADDR):
- +0 CTRL, RW:
  - bit0 `enable` (reset 1).
  - bit1 `clear`, write-only, self-clearing, reads as 0.
- +1 STATUS, RO: [15:8] FIFO level (saturates at 255), bit1 full, bit0 empty.
- +2 DATA, RO, pops the FIFO: {valid, 6'b0, last, byte}. When the FIFO is empty it returns 0 and does not pop.
- +3 FRAME_CNT, RO: completed frames, 16-bit, wraps.
- +4 DROP_CNT, RO: bytes dropped because the FIFO was full, 16-bit, saturates at 16'hFFFF.
- +5 LAST_LEN, RO: byte length of the most recently completed frame, 16-bit, saturates.

Capture path:
- A one-byte hold register delays each byte so the `last` flag can be attached to it.
- A byte accepted while the hold register is valid pushes the held byte with last=0, then loads the new byte.
- At a falling edge of `rx_dv` (high last cycle, low now), the held byte is pushed with last=1, the hold register is invalidated, FRAME_CNT increments, and LAST_LEN is loaded with the frame's byte count.
- Frame byte counter: 16-bit, saturating. It counts every byte of the frame, including dropped bytes.
- `enable` is sampled only on the first byte of a frame. That decision (accept or ignore) holds for the whole frame. An ignored frame touches no FIFO entry or counter.
- Push while full: the entry is dropped and DROP_CNT increments. Fullness is evaluated before the edge, so a pop in the same cycle does not make room.
- Pop and push in the same cycle are both honoured when the FIFO is neither empty (for the pop) nor full (for the push).

Clear (write to CTRL with bit1=1):
- Takes effect at that edge.
- Flushes the FIFO, zeroes FRAME_CNT, DROP_CNT and LAST_LEN, and invalidates the hold register.
- Any frame in progress is discarded until `rx_dv` is next low.
- `enable` takes bit0 of the same write.

Bus behaviour:
- Writes to any address other than CTRL are ignored.
- Reads of addresses outside the map return 0.

## Timing
- Reset (asynchronous assert): `bus_rd_data`=0, `fifo_nempty`=0, FIFO empty, all counters 0, hold register invalid, `enable`=1, no frame in progress.
- Read latency: `bus_rd_data` is updated at the edge that samples `bus_cmd_valid`=1 with `bus_op`=0. The value is valid the next cycle and held until the next read.
- A DATA pop takes effect at that same edge.
- Push latency:
  - A mid-frame byte enters the FIFO at the edge that samples the following byte.
  - The final byte enters at the edge that samples `rx_dv`=0.
  - `fifo_nempty` rises in the cycle after that push.
- FRAME_CNT and LAST_LEN update at the same edge as the final-byte push.
- Back-to-back frames need ≥1 idle cycle of `rx_dv`=0. With no gap, consecutive bytes form one frame.
- Reset asserted mid-frame: all state is cleared immediately. Bytes still on `rx_dv` after deassertion are treated as a new frame.

## Test plan
- Frame of 3 bytes (A1, B2, C3), `enable`=1. Three DATA reads return 16'h80A1, 16'h80B2, 16'h81C3. A fourth read returns 0. FRAME_CNT=1, LAST_LEN=3.
- DEPTH=16, one 20-byte frame with no reads. STATUS={8'd16, 6'b0, 1, 0}, DROP_CNT=4. The 16th DATA read has last=0, because the last byte was dropped.
- CTRL write 0, then a 5-byte frame, then CTRL write 1, then a 2-byte frame. FRAME_CNT=1, LAST_LEN=2, FIFO level 2.
- A CTRL write of 16'h0003 during the 2nd byte of a 6-byte frame. The FIFO stays empty, all counters are 0, and the next frame is captured normally.
- A DATA pop in the same cycle as a push with FIFO level 1. Level stays 1 and the entry order is preserved.
- `rst_n` pulsed low mid-frame: all registers read their reset values. Reads of 0x00 and 0x16 return 0.

Source files
------------

// File: rtl/rx_frame_collector_if.sv
// Signal bundle between the upstream byte source / bus agent and the
// frame collector. The master drives the byte stream and bus commands.
// The slave (the collector) returns read data and the FIFO-not-empty flag.
interface rx_frame_collector_if;
  logic [7:0]  rxd;
  logic        rx_dv;
  logic        bus_cmd_valid;
  logic        bus_op;
  logic [15:0] bus_addr;
  logic [15:0] bus_wr_data;
  logic [15:0] bus_rd_data;
  logic        fifo_nempty;

  modport master (
    output rxd, rx_dv, bus_cmd_valid, bus_op, bus_addr, bus_wr_data,
    input  bus_rd_data, fifo_nempty
  );

  modport slave (
    input  rxd, rx_dv, bus_cmd_valid, bus_op, bus_addr, bus_wr_data,
    output bus_rd_data, fifo_nempty
  );
endinterface

// File: rtl/rx_frame_collector.sv
// Frame collector: delimits frames on rx_dv, tags the final byte of each
// frame with a last flag through a one-byte hold register, buffers
// {last, byte} entries in a FIFO and exposes FIFO plus statistics on the
// register bus.
//
// Handshake: a bus command is a one-cycle strobe (bus_cmd_valid) with no
// ready/backpressure. Every strobe is accepted at the edge that samples it.
// A read loads bus_rd_data at that same edge and the value holds until the
// next read. The byte stream has no backpressure either: a byte that finds
// the FIFO full is dropped and counted.
module rx_frame_collector #(
  parameter int          DEPTH     = 16,
  parameter logic [15:0] BASE_ADDR = 16'h10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rx_frame_collector_if.slave   io,
  output logic [1:0]            dbg_state
);

  localparam int AW = $clog2(DEPTH);

  // ST_IDLE: no frame. ST_CAPTURE: accepted frame, hold register valid.
  // ST_SKIP: ignored or cleared frame, waiting for rx_dv to drop.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SKIP    = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        enable;
  logic [7:0]  hold_data;
  logic [15:0] byte_cnt;
  logic [15:0] frame_cnt, drop_cnt, last_len;
  logic [8:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, count;
  logic        empty, full;

  logic        load_hold, first_byte, push_req, push_last, frame_done;
  logic        wr_cmd, rd_cmd, in_map, ctrl_wr, clear_wr, pop_req;
  logic        push_ok, push_drop, pop_ok;
  logic [15:0] offset, level16, rd_next;
  logic [7:0]  level8;
  logic        wr_data_unused;

  assign dbg_state      = state;
  assign wr_data_unused = ^io.bus_wr_data[15:2];

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign io.fifo_nempty = !empty;

  assign level16 = 16'(count);
  assign level8  = (level16 > 16'd255) ? 8'hFF : level16[7:0];

  assign wr_cmd   = io.bus_cmd_valid &&  io.bus_op;
  assign rd_cmd   = io.bus_cmd_valid && !io.bus_op;
  assign offset   = io.bus_addr - BASE_ADDR;
  assign in_map   = (offset < 16'd6);
  assign ctrl_wr  = wr_cmd && (offset == 16'd0);
  assign clear_wr = ctrl_wr && io.bus_wr_data[1];
  assign pop_req  = rd_cmd && (offset == 16'd2);

  // Fullness and emptiness are judged on the pre-edge level; clear wins.
  assign push_ok   = push_req &&  !full && !clear_wr;
  assign push_drop = push_req &&   full && !clear_wr;
  assign pop_ok    = pop_req  && !empty && !clear_wr;

  // Frame FSM next state and capture-path strobes.
  always_comb begin
    state_nxt  = state;
    load_hold  = 1'b0;
    first_byte = 1'b0;
    push_req   = 1'b0;
    push_last  = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (io.rx_dv) begin
          if (enable) begin
            state_nxt  = ST_CAPTURE;
            load_hold  = 1'b1;
            first_byte = 1'b1;
          end else begin
            state_nxt = ST_SKIP;
          end
        end
      end
      ST_CAPTURE: begin
        push_req = 1'b1;
        if (io.rx_dv) begin
          load_hold = 1'b1;
        end else begin
          push_last  = 1'b1;
          frame_done = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      ST_SKIP: begin
        if (!io.rx_dv) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A clear discards the frame in flight until rx_dv is next low.
    if (clear_wr) state_nxt = io.rx_dv ? ST_SKIP : ST_IDLE;
  end

  // Frame FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Hold register and saturating per-frame byte counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data <= '0;
      byte_cnt  <= '0;
    end else begin
      if (load_hold) hold_data <= io.rxd;
      if (first_byte)
        byte_cnt <= 16'd1;
      else if (load_hold && byte_cnt != 16'hFFFF)
        byte_cnt <= byte_cnt + 16'd1;
    end
  end

  // Enable bit and statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable    <= 1'b1;
      frame_cnt <= '0;
      drop_cnt  <= '0;
      last_len  <= '0;
    end else begin
      if (ctrl_wr) enable <= io.bus_wr_data[0];
      if (clear_wr) begin
        frame_cnt <= '0;
        drop_cnt  <= '0;
        last_len  <= '0;
      end else begin
        if (push_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        if (frame_done) begin
          frame_cnt <= frame_cnt + 16'd1;
          last_len  <= byte_cnt;
        end
      end
    end
  end

  // FIFO pointers; clear flushes by resetting both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear_wr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= {push_last, hold_data};
  end

  // Register read multiplexer.
  always_comb begin
    rd_next = '0;
    if (in_map) begin
      case (offset[2:0])
        3'd0: rd_next = {15'd0, enable};
        3'd1: rd_next = {level8, 6'd0, full, empty};
        3'd2: rd_next = empty ? 16'd0 : {1'b1, 6'd0, mem[rd_ptr[AW-1:0]]};
        3'd3: rd_next = frame_cnt;
        3'd4: rd_next = drop_cnt;
        3'd5: rd_next = last_len;
        default: rd_next = '0;
      endcase
    end
  end

  // Registered read data, updated only by read commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      io.bus_rd_data <= '0;
    else if (rd_cmd) io.bus_rd_data <= rd_next;
  end

endmodule

// File: tb/tb_rx_frame_collector.sv
// Bench for rx_frame_collector: scenario tasks drive frames and bus
// commands; expected DATA reads are queued as bytes are driven and
// compared as they are read back.
module tb_rx_frame_collector;

  localparam int          DEPTH  = 16;
  localparam logic [15:0] A_CTRL = 16'h10;
  localparam logic [15:0] A_STAT = 16'h11;
  localparam logic [15:0] A_DATA = 16'h12;
  localparam logic [15:0] A_FCNT = 16'h13;
  localparam logic [15:0] A_DROP = 16'h14;
  localparam logic [15:0] A_LLEN = 16'h15;

  logic        clk;
  logic        rst_n;
  logic [1:0]  dbg_state;
  int          checks;
  int          errors;

  logic [15:0] exp_q[$];
  logic [15:0] m_frames, m_drop, m_last_len;
  logic [7:0]  fb [0:31];

  rx_frame_collector_if bus_if();

  rx_frame_collector #(.DEPTH(DEPTH), .BASE_ADDR(16'h10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .io        (bus_if.slave),
    .dbg_state (dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    bus_if.bus_cmd_valid = 1'b1;
    bus_if.bus_op        = 1'b0;
    bus_if.bus_addr      = a;
    @(negedge clk);
    bus_if.bus_cmd_valid = 1'b0;
    d = bus_if.bus_rd_data;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] v);
    @(negedge clk);
    bus_if.bus_cmd_valid = 1'b1;
    bus_if.bus_op        = 1'b1;
    bus_if.bus_addr      = a;
    bus_if.bus_wr_data   = v;
    @(negedge clk);
    bus_if.bus_cmd_valid = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_frames   = '0;
    m_drop     = '0;
    m_last_len = '0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit last);
    if (exp_q.size() < DEPTH) exp_q.push_back({1'b1, 6'd0, last, b});
    else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
  endtask

  task automatic model_frame_end(input int n);
    m_frames   = m_frames + 16'd1;
    m_last_len = (n > 65535) ? 16'hFFFF : 16'(n);
  endtask

  // Drives fb[0..n-1] as one frame followed by one idle cycle start.
  task automatic send_frame(input int n, input bit accept);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus_if.rx_dv = 1'b1;
      bus_if.rxd   = fb[i];
      if (accept) model_byte(fb[i], (i == n - 1));
    end
    @(negedge clk);
    bus_if.rx_dv = 1'b0;
    if (accept) model_frame_end(n);
  endtask

  task automatic do_clear();
    bus_write(A_CTRL, 16'h0003);
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [15:0] d;
    logic [15:0] exp_regs [0:4];
    logic [15:0] addrs [0:4];
    rst_n = 1'b0;
    bus_if.rxd = '0; bus_if.rx_dv = 1'b0; bus_if.bus_cmd_valid = 1'b0;
    bus_if.bus_op = 1'b0; bus_if.bus_addr = '0; bus_if.bus_wr_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (bus_if.bus_rd_data !== 16'h0) begin
      errors++; $display("FAIL reset_rd_data got %h exp %h", bus_if.bus_rd_data, 16'h0);
    end
    checks++;
    if (bus_if.fifo_nempty !== 1'b0) begin
      errors++; $display("FAIL reset_nempty got %b exp 0", bus_if.fifo_nempty);
    end
    rst_n = 1'b1;
    addrs = '{A_CTRL, A_STAT, A_FCNT, A_DROP, A_LLEN};
    exp_regs = '{16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000};
    for (int i = 0; i < 5; i++) begin
      bus_read(addrs[i], d);
      checks++;
      if (d !== exp_regs[i]) begin
        errors++; $display("FAIL reset_reg[%h] got %h exp %h", addrs[i], d, exp_regs[i]);
      end
    end
  endtask

  task automatic test_basic_frame();
    logic [15:0] d, e;
    fb[0] = 8'hA1; fb[1] = 8'hB2; fb[2] = 8'hC3;
    send_frame(3, 1'b1);
    @(negedge clk);
    checks++;
    if (bus_if.fifo_nempty !== 1'b1) begin
      errors++; $display("FAIL basic_nempty got %b exp 1", bus_if.fifo_nempty);
    end
    for (int i = 0; i < 4; i++) begin
      bus_read(A_DATA, d);
      e = 16'h0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      checks++;
      if (d !== e) begin
        errors++; $display("FAIL basic_data[%0d] got %h exp %h", i, d, e);
      end
    end
    bus_read(A_FCNT, d);
    checks++;
    if (d !== m_frames) begin errors++; $display("FAIL basic_frame_cnt got %h exp %h", d, m_frames); end
    bus_read(A_LLEN, d);
    checks++;
    if (d !== m_last_len) begin errors++; $display("FAIL basic_last_len got %h exp %h", d, m_last_len); end
  endtask

  task automatic test_overflow();
    logic [15:0] d, e, es;
    do_clear();
    for (int i = 0; i < 20; i++) fb[i] = 8'($urandom_range(0, 255));
    send_frame(20, 1'b1);
    @(negedge clk);
    es = {8'(exp_q.size()), 6'd0, (exp_q.size() == DEPTH), (exp_q.size() == 0)};
    bus_read(A_STAT, d);
    checks++;
    if (d !== es) begin errors++; $display("FAIL ovf_status got %h exp %h", d, es); end
    bus_read(A_DROP, d);
    checks++;
    if (d !== m_drop) begin errors++; $display("FAIL ovf_drop_cnt got %h exp %h", d, m_drop); end
    bus_read(A_LLEN, d);
    checks++;
    if (d !== m_last_len) begin errors++; $display("FAIL ovf_last_len got %h exp %h", d, m_last_len); end
    for (int i = 0; i < 17; i++) begin
      bus_read(A_DATA, d);
      e = 16'h0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      checks++;
      if (d !== e) begin errors++; $display("FAIL ovf_data[%0d] got %h exp %h", i, d, e); end
    end
  endtask

  task automatic test_enable();
    logic [15:0] d, e, es;
    do_clear();
    bus_write(A_CTRL, 16'h0000);
    for (int i = 0; i < 5; i++) fb[i] = 8'(8'h30 + i);
    send_frame(5, 1'b0);
    bus_write(A_CTRL, 16'h0001);
    fb[0] = 8'h44; fb[1] = 8'h55;
    send_frame(2, 1'b1);
    @(negedge clk);
    bus_read(A_FCNT, d);
    checks++;
    if (d !== m_frames) begin errors++; $display("FAIL en_frame_cnt got %h exp %h", d, m_frames); end
    bus_read(A_LLEN, d);
    checks++;
    if (d !== m_last_len) begin errors++; $display("FAIL en_last_len got %h exp %h", d, m_last_len); end
    es = {8'(exp_q.size()), 6'd0, (exp_q.size() == DEPTH), (exp_q.size() == 0)};
    bus_read(A_STAT, d);
    checks++;
    if (d !== es) begin errors++; $display("FAIL en_status got %h exp %h", d, es); end
    for (int i = 0; i < 3; i++) begin
      bus_read(A_DATA, d);
      e = 16'h0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      checks++;
      if (d !== e) begin errors++; $display("FAIL en_data[%0d] got %h exp %h", i, d, e); end
    end
  endtask

  task automatic test_clear_mid_frame();
    logic [15:0] d, e;
    logic [15:0] addrs [0:4];
    logic [15:0] exp_regs [0:4];
    do_clear();
    fb[0] = 8'h01; fb[1] = 8'h02;
    send_frame(2, 1'b1);
    for (int i = 0; i < 6; i++) fb[i] = 8'(8'h60 + i);
    @(negedge clk);
    bus_if.rx_dv = 1'b1; bus_if.rxd = fb[0];
    @(negedge clk);
    bus_if.rxd = fb[1];
    bus_if.bus_cmd_valid = 1'b1; bus_if.bus_op = 1'b1;
    bus_if.bus_addr = A_CTRL; bus_if.bus_wr_data = 16'h0003;
    for (int i = 2; i < 6; i++) begin
      @(negedge clk);
      bus_if.bus_cmd_valid = 1'b0;
      bus_if.rxd = fb[i];
    end
    @(negedge clk);
    bus_if.rx_dv = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (bus_if.fifo_nempty !== 1'b0) begin
      errors++; $display("FAIL clr_nempty got %b exp 0", bus_if.fifo_nempty);
    end
    addrs = '{A_CTRL, A_STAT, A_FCNT, A_DROP, A_LLEN};
    exp_regs = '{16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000};
    for (int i = 0; i < 5; i++) begin
      bus_read(addrs[i], d);
      checks++;
      if (d !== exp_regs[i]) begin
        errors++; $display("FAIL clr_reg[%h] got %h exp %h", addrs[i], d, exp_regs[i]);
      end
    end
    fb[0] = 8'h7A; fb[1] = 8'h7B; fb[2] = 8'h7C;
    send_frame(3, 1'b1);
    bus_read(A_FCNT, d);
    checks++;
    if (d !== m_frames) begin errors++; $display("FAIL clr_next_frame_cnt got %h exp %h", d, m_frames); end
    for (int i = 0; i < 4; i++) begin
      bus_read(A_DATA, d);
      e = 16'h0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      checks++;
      if (d !== e) begin errors++; $display("FAIL clr_data[%0d] got %h exp %h", i, d, e); end
    end
  endtask

  task automatic test_pop_push_same_cycle();
    logic [15:0] d, e;
    do_clear();
    fb[0] = 8'h5A;
    send_frame(1, 1'b1);
    @(negedge clk);
    bus_if.rx_dv = 1'b1; bus_if.rxd = 8'hC0;
    model_byte(8'hC0, 1'b0);
    @(negedge clk);
    bus_if.rxd = 8'hC1;
    model_byte(8'hC1, 1'b1);
    bus_if.bus_cmd_valid = 1'b1; bus_if.bus_op = 1'b0; bus_if.bus_addr = A_DATA;
    @(negedge clk);
    bus_if.rx_dv = 1'b0;
    model_frame_end(2);
    bus_if.bus_addr = A_STAT;
    d = bus_if.bus_rd_data;
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("FAIL pp_data_pop got %h exp %h", d, e); end
    @(negedge clk);
    bus_if.bus_cmd_valid = 1'b0;
    d = bus_if.bus_rd_data;
    checks++;
    if (d !== 16'h0100) begin errors++; $display("FAIL pp_level got %h exp %h", d, 16'h0100); end
    for (int i = 0; i < 3; i++) begin
      bus_read(A_DATA, d);
      e = 16'h0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      checks++;
      if (d !== e) begin errors++; $display("FAIL pp_data[%0d] got %h exp %h", i, d, e); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] d, e;
    logic [15:0] addrs [0:7];
    logic [15:0] exp_regs [0:7];
    do_clear();
    fb[0] = 8'h91; fb[1] = 8'h92;
    send_frame(2, 1'b1);
    bus_read(A_CTRL, d);
    @(negedge clk);
    bus_if.rx_dv = 1'b1; bus_if.rxd = 8'h11;
    @(negedge clk);
    bus_if.rxd = 8'h22;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus_if.fifo_nempty !== 1'b0 || bus_if.bus_rd_data !== 16'h0) begin
      errors++;
      $display("FAIL rst_async got nempty=%b rd=%h exp nempty=0 rd=0000",
               bus_if.fifo_nempty, bus_if.bus_rd_data);
    end
    bus_if.rx_dv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    addrs = '{A_CTRL, A_STAT, A_DATA, A_FCNT, A_DROP, A_LLEN, 16'h0000, 16'h0016};
    exp_regs = '{16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      bus_read(addrs[i], d);
      checks++;
      if (d !== exp_regs[i]) begin
        errors++; $display("FAIL rst_reg[%h] got %h exp %h", addrs[i], d, exp_regs[i]);
      end
    end
    // Reset pulse with rx_dv still high: remaining bytes form a new frame.
    for (int i = 0; i < 5; i++) fb[i] = 8'(8'hE0 + i);
    @(negedge clk); bus_if.rx_dv = 1'b1; bus_if.rxd = fb[0];
    @(negedge clk); bus_if.rxd = fb[1];
    @(negedge clk); bus_if.rxd = fb[2];
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    model_byte(fb[2], 1'b0);
    @(negedge clk); bus_if.rxd = fb[3];
    model_byte(fb[3], 1'b0);
    @(negedge clk); bus_if.rxd = fb[4];
    model_byte(fb[4], 1'b1);
    @(negedge clk); bus_if.rx_dv = 1'b0;
    model_frame_end(3);
    bus_read(A_FCNT, d);
    checks++;
    if (d !== m_frames) begin errors++; $display("FAIL rstmid_frame_cnt got %h exp %h", d, m_frames); end
    bus_read(A_LLEN, d);
    checks++;
    if (d !== m_last_len) begin errors++; $display("FAIL rstmid_last_len got %h exp %h", d, m_last_len); end
    for (int i = 0; i < 4; i++) begin
      bus_read(A_DATA, d);
      e = 16'h0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      checks++;
      if (d !== e) begin errors++; $display("FAIL rstmid_data[%0d] got %h exp %h", i, d, e); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_frame();
    test_overflow();
    test_enable();
    test_clear_mid_frame();
    test_pop_push_same_cycle();
    test_reset_mid_frame();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
